fft_frame_writer: RTL

- Sits directly downstream of the I2S capture ADC stage and upstream of the FFT BRAM controller.
- Consumes one left-justified 32-bit sample per ADC flag handshake. Writes samples sequentially into a two-bank (ping-pong) BRAM frame buffer.
- Raises a frame-complete pulse when a bank holds a full frame, so the FFT side can read it while the other bank fills.
- Runs on the ADC serial clock domain; no CDC inside the block.

---
 rtl/fft_frame_pkg.sv | 18 +
 rtl/fft_bank_tracker.sv | 28 ++
 rtl/fft_frame_writer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fft_frame_pkg.sv
// Shared types and defaults for the FFT ping-pong frame writer.
package fft_frame_pkg;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 32;

  typedef logic bank_t;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait  = 3'd1,
    StWrite = 3'd2,
    StDrop  = 3'd3,
    StAck   = 3'd4,
    StClr   = 3'd5
  } fsm_state_e;

endpackage

// File: rtl/fft_bank_tracker.sv
// Per-bank full flags: set on frame completion, cleared on FFT release; set beats release.
module fft_bank_tracker
  import fft_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  bank_t      set_bank,
  input  logic       rel_en,
  input  bank_t      rel_bank,
  output logic [1:0] bank_full
);

  logic [1:0] full_d;

  // Release applied first so a same-bank set overrides it.
  always_comb begin
    full_d = bank_full;
    if (rel_en) full_d[rel_bank] = 1'b0;
    if (set_en) full_d[set_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bank_full <= 2'b00;
    else     bank_full <= full_d;
  end

endmodule

// File: rtl/fft_frame_writer.sv
// Writes ADC samples into a two-bank BRAM frame buffer with a flag/ack handshake.
// Optional FRAME_WRITER_DROP_CNT_EN adds a saturating drop_count output.
module fft_frame_writer
  import fft_frame_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_valid,
  output logic              smp_ack,
  output logic              bram_we,
  output logic [ADDR_W:0]   bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              frame_done,
  output logic              frame_bank,
  input  logic              fft_release,
  input  logic              release_bank,
  output logic [1:0]        bank_full,
`ifdef FRAME_WRITER_DROP_CNT_EN
  output logic [15:0]       drop_count,
`endif
  output logic              overflow
);

  fsm_state_e        state;
  bank_t             wr_bank;
  logic [ADDR_W-1:0] wr_idx;
  logic              accept;
  logic              frame_end;

  assign accept    = (state == StWait) && enable && smp_valid && !bank_full[wr_bank];
  assign frame_end = accept && (&wr_idx);

  fft_bank_tracker u_bank_tracker (
    .clk       (clk),
    .rst       (rst),
    .set_en    (frame_end),
    .set_bank  (wr_bank),
    .rel_en    (fft_release),
    .rel_bank  (release_bank),
    .bank_full (bank_full)
  );

  // Outputs are registered on entry to a state so they are visible during that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      smp_ack    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      frame_done <= 1'b0;
      frame_bank <= 1'b0;
      overflow   <= 1'b0;
`ifdef FRAME_WRITER_DROP_CNT_EN
      drop_count <= 16'd0;
`endif
    end else begin
      bram_we    <= 1'b0;
      frame_done <= 1'b0;
      smp_ack    <= 1'b0;
      unique case (state)
        StIdle: begin
          if (enable) state <= StWait;
        end
        StWait: begin
          if (!enable) begin
            state  <= StIdle;
            wr_idx <= '0;
          end else if (smp_valid) begin
            if (!bank_full[wr_bank]) begin
              state     <= StWrite;
              bram_we   <= 1'b1;
              bram_addr <= {wr_bank, wr_idx};
              bram_din  <= smp_data;
              wr_idx    <= wr_idx + ADDR_W'(1);
              if (&wr_idx) begin
                frame_done <= 1'b1;
                frame_bank <= wr_bank;
                wr_bank    <= ~wr_bank;
              end
            end else begin
              state    <= StDrop;
              overflow <= 1'b1;
`ifdef FRAME_WRITER_DROP_CNT_EN
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
            end
          end
        end
        StWrite, StDrop: begin
          smp_ack <= 1'b1;
          state   <= StAck;
        end
        StAck: begin
          state <= StClr;
        end
        StClr: begin
          // Wait for the ADC to drop its flag so one sample never writes twice.
          if (!smp_valid) begin
            if (enable) begin
              state <= StWait;
            end else begin
              state  <= StIdle;
              wr_idx <= '0;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
